// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Demand-driven phase controller for a two-road intersection with a
// pedestrian walk phase. Road A and road B alternate green; a latched
// pedestrian request inserts a walk phase after the next all-red clearance.
// All durations are counted in clock cycles. Every output is registered and
// decoded from the next state, so lamps and phase change on the same edge.
// The phase output carries the FSM state code for debug observation.
module traffic_phase_scheduler #(
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2,
    parameter int WALK      = 8,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sens_A,
    input  logic       sens_B,
    input  logic       ped_req,
    output logic [2:0] traffic_A,
    output logic [2:0] traffic_B,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [2:0] A_GRN    = 3'd0;
    localparam logic [2:0] A_YEL    = 3'd1;
    localparam logic [2:0] A_CLR    = 3'd2;
    localparam logic [2:0] B_GRN    = 3'd3;
    localparam logic [2:0] B_YEL    = 3'd4;
    localparam logic [2:0] B_CLR    = 3'd5;
    localparam logic [2:0] PED_WALK = 3'd6;
    localparam logic [2:0] PED_CLR  = 3'd7;

    // Lamp encodings {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Last counter value of each timed interval
    localparam logic [CNT_W-1:0] MIN_END  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_END  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] CLR_END  = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] WALK_END = CNT_W'(WALK - 1);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             next_b;
    logic             exit_a;
    logic             exit_b;
    logic             is_green;
    logic             in_ped;
    logic             enter_walk;
    logic [2:0]       lamp_a_d;
    logic [2:0]       lamp_b_d;
    logic             walk_d;

    // Green exit: min green served, opposing demand present, and either own
    // road has gapped out or max green is reached (counter saturates there).
    always_comb begin
        exit_a = (cnt >= MIN_END) && (sens_B || ped_pending) &&
                 (!sens_A || (cnt == MAX_END));
        exit_b = (cnt >= MIN_END) && (sens_A || ped_pending) &&
                 (!sens_B || (cnt == MAX_END));
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            A_GRN:    if (exit_a) next_state = A_YEL;
            A_YEL:    if (cnt == YEL_END) next_state = A_CLR;
            A_CLR:    if (cnt == CLR_END) next_state = ped_pending ? PED_WALK : B_GRN;
            B_GRN:    if (exit_b) next_state = B_YEL;
            B_YEL:    if (cnt == YEL_END) next_state = B_CLR;
            B_CLR:    if (cnt == CLR_END) next_state = ped_pending ? PED_WALK : A_GRN;
            PED_WALK: if (cnt == WALK_END) next_state = PED_CLR;
            PED_CLR:  if (cnt == CLR_END) next_state = next_b ? B_GRN : A_GRN;
            default:  next_state = B_CLR;
        endcase
    end

    // Counter: restart on entry, count up, hold at max green in green states
    always_comb begin
        is_green = (state == A_GRN) || (state == B_GRN);
        if (next_state != state)
            cnt_next = '0;
        else if (is_green && (cnt == MAX_END))
            cnt_next = cnt;
        else
            cnt_next = cnt + CNT_W'(1);
    end

    // Pedestrian latch controls: requests are ignored during the walk phase
    // and its clearance, and entering the walk clears the latch.
    always_comb begin
        in_ped     = (state == PED_WALK) || (state == PED_CLR);
        enter_walk = (next_state == PED_WALK) && (state != PED_WALK);
    end

    // Output decode from the next state so outputs align with phase
    always_comb begin
        lamp_a_d = LAMP_RED;
        lamp_b_d = LAMP_RED;
        walk_d   = 1'b0;
        case (next_state)
            A_GRN:    lamp_a_d = LAMP_GRN;
            A_YEL:    lamp_a_d = LAMP_YEL;
            B_GRN:    lamp_b_d = LAMP_GRN;
            B_YEL:    lamp_b_d = LAMP_YEL;
            PED_WALK: walk_d   = 1'b1;
            default:  ;
        endcase
    end

    // State, counter and road-alternation flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= B_CLR;
            cnt    <= '0;
            next_b <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if ((state == A_CLR) && (cnt == CLR_END))
                next_b <= 1'b1;
            else if ((state == B_CLR) && (cnt == CLR_END))
                next_b <= 1'b0;
        end
    end

    // Pedestrian request latch; clear on walk entry wins over a new request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ped_pending <= 1'b0;
        else if (enter_walk)
            ped_pending <= 1'b0;
        else if (ped_req && !in_ped)
            ped_pending <= 1'b1;
    end

    // Registered lamp, walk and debug phase outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            traffic_A <= LAMP_RED;
            traffic_B <= LAMP_RED;
            walk      <= 1'b0;
            phase     <= B_CLR;
        end else begin
            traffic_A <= lamp_a_d;
            traffic_B <= lamp_b_d;
            walk      <= walk_d;
            phase     <= next_state;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler
// Directed bench for traffic_phase_scheduler. Expected per-cycle outputs are
// pushed to a queue as each step is set up and popped one per clock cycle,
// sampled 1 time unit after the rising edge.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       rst;
    logic       sens_A;
    logic       sens_B;
    logic       ped_req;
    logic [2:0] traffic_A;
    logic [2:0] traffic_B;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    // Packed observation: {traffic_A, traffic_B, walk, ped_pending, phase}
    logic [10:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    string       tag;

    traffic_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .sens_A      (sens_A),
        .sens_B      (sens_B),
        .ped_req     (ped_req),
        .traffic_A   (traffic_A),
        .traffic_B   (traffic_B),
        .walk        (walk),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output word for a phase code and pending flag, from the lamp table
    function automatic logic [10:0] exp_word(input logic [2:0] ph, input logic pend);
        logic [2:0] la;
        logic [2:0] lb;
        logic       w;
        la = 3'b100;
        lb = 3'b100;
        w  = 1'b0;
        case (ph)
            3'd0: la = 3'b001;
            3'd1: la = 3'b010;
            3'd3: lb = 3'b001;
            3'd4: lb = 3'b010;
            3'd6: w  = 1'b1;
            default: ;
        endcase
        return {la, lb, w, pend, ph};
    endfunction

    // Push n copies of an expected cycle
    task automatic push_exp(input logic [2:0] ph, input logic pend, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(exp_word(ph, pend));
    endtask

    // Pop one expectation and compare against the current outputs
    task automatic compare_now();
        logic [10:0] obs;
        logic [10:0] exp;
        obs = {traffic_A, traffic_B, walk, ped_pending, phase};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h with empty expected queue", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed A=%b B=%b walk=%b pend=%b phase=%0d expected A=%b B=%b walk=%b pend=%b phase=%0d",
                       tag, obs[10:8], obs[7:5], obs[4], obs[3], obs[2:0],
                       exp[10:8], exp[7:5], exp[4], exp[3], exp[2:0]);
            end
        end
    endtask

    // One comparison per clock cycle until the queue is empty
    task automatic drain();
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            compare_now();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sens_A   = 1'b0;
        sens_B   = 1'b0;
        ped_req  = 1'b0;
        rst      = 1'b1;

        // Reset at power-up, checked before any clock edge
        tag = "reset_async";
        #1 rst = 1'b0;
        #2;
        push_exp(3'd5, 1'b0, 1);
        compare_now();

        tag = "reset_held";
        push_exp(3'd5, 1'b0, 2);
        drain();

        // Release: one more all-red cycle, then A green on the 2nd edge; no demand
        tag = "release_no_demand";
        rst = 1'b1;
        push_exp(3'd5, 1'b0, 1);
        push_exp(3'd0, 1'b0, 100);
        drain();

        // Late demand on B with A saturated and sens_A low: exits on next edge
        tag = "late_demand";
        sens_B = 1'b1;
        push_exp(3'd1, 1'b0, 3);
        push_exp(3'd2, 1'b0, 2);
        push_exp(3'd3, 1'b0, 1);
        drain();

        // Both sensors held: B runs to max green (30 cycles total)
        tag = "maxout_b";
        sens_A = 1'b1;
        push_exp(3'd3, 1'b0, 29);
        push_exp(3'd4, 1'b0, 3);
        push_exp(3'd5, 1'b0, 2);
        push_exp(3'd0, 1'b0, 1);
        drain();

        tag = "maxout_a";
        push_exp(3'd0, 1'b0, 29);
        push_exp(3'd1, 1'b0, 3);
        push_exp(3'd2, 1'b0, 2);
        push_exp(3'd3, 1'b0, 1);
        drain();

        // Gap-out on B: only A demand from B entry, exactly 10 green cycles
        tag = "gapout_b";
        sens_A = 1'b1;
        sens_B = 1'b0;
        push_exp(3'd3, 1'b0, 9);
        push_exp(3'd4, 1'b0, 3);
        push_exp(3'd5, 1'b0, 2);
        push_exp(3'd0, 1'b0, 1);
        drain();

        // Gap-out on A: only B demand from A entry
        tag = "gapout_a";
        sens_A = 1'b0;
        sens_B = 1'b1;
        push_exp(3'd0, 1'b0, 9);
        push_exp(3'd1, 1'b0, 3);
        push_exp(3'd2, 1'b0, 2);
        push_exp(3'd3, 1'b0, 1);
        drain();

        // Return to A via another B gap-out
        tag = "return_to_a";
        sens_A = 1'b1;
        sens_B = 1'b0;
        push_exp(3'd3, 1'b0, 9);
        push_exp(3'd4, 1'b0, 3);
        push_exp(3'd5, 1'b0, 2);
        push_exp(3'd0, 1'b0, 1);
        drain();

        // Single-cycle pedestrian request in A green with no vehicles
        tag = "ped_pulse";
        sens_A  = 1'b0;
        ped_req = 1'b1;
        push_exp(3'd0, 1'b1, 1);
        drain();
        ped_req = 1'b0;
        tag = "ped_walk";
        push_exp(3'd0, 1'b1, 8);
        push_exp(3'd1, 1'b1, 3);
        push_exp(3'd2, 1'b1, 2);
        push_exp(3'd6, 1'b0, 8);
        push_exp(3'd7, 1'b0, 2);
        push_exp(3'd3, 1'b0, 1);
        drain();

        // Request held through walk entry, walk and clearance: one walk only
        tag = "ped_collision";
        ped_req = 1'b1;
        push_exp(3'd3, 1'b1, 9);
        push_exp(3'd4, 1'b1, 3);
        push_exp(3'd5, 1'b1, 2);
        push_exp(3'd6, 1'b0, 8);
        push_exp(3'd7, 1'b0, 2);
        drain();
        ped_req = 1'b0;
        tag = "ped_no_second_walk";
        push_exp(3'd0, 1'b0, 15);
        drain();

        // Move to B green and rest there
        tag = "to_b_rest";
        sens_B = 1'b1;
        push_exp(3'd1, 1'b0, 3);
        push_exp(3'd2, 1'b0, 2);
        push_exp(3'd3, 1'b0, 5);
        drain();

        // Reset mid B green: outputs change without a clock edge
        tag = "reset_mid_b_grn";
        rst = 1'b0;
        #2;
        push_exp(3'd5, 1'b0, 1);
        compare_now();
        push_exp(3'd5, 1'b0, 1);
        drain();

        tag = "release_after_mid_reset";
        rst    = 1'b1;
        sens_B = 1'b0;
        push_exp(3'd5, 1'b0, 1);
        push_exp(3'd0, 1'b0, 3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
